mod_38_down_counter: RTL and testbench
======================================

Name: mod_38_down_counter

Overview:
Loadable modulo-38 down counter, the count-down counterpart to the team's loadable mod-38 up counter. Shares the same load interface: 6-bit preset `data` plus a one-cycle `load` strobe. Counts from the preset toward zero, wraps to MOD-1 and flags a terminal-count pulse. Used as a reload timer alongside the up counter in the counter-block family.

Parameters:
MOD, 38, modulus; legal count range 0..MOD-1
WIDTH, 6, counter width; must satisfy 2^WIDTH >= MOD

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
data  input  WIDTH  preset value, sampled when load=1
load  input  1  load strobe; highest priority after rst
en  input  1  count enable; decrement when high in COUNT/PAUSE
dout  output  WIDTH  current count (registered)
tc  output  1  terminal-count pulse, one cycle, registered
busy  output  1  high when state is COUNT or PAUSE
load_err  output  1  sticky flag: last load carried data >= MOD

Behaviour:
- All outputs registered; all updates on rising clk edge.
- Priority each cycle: rst > load > en/state logic.
- rst=1 on a clock edge:
  - dout=0, tc=0, busy=0, load_err=0, state=IDLE.
  - Applies mid-count; any load or en in the same cycle is ignored.
- States: IDLE, COUNT, PAUSE (2-bit encoding; the fourth code recovers to IDLE).
- IDLE: dout holds; en ignored; busy=0. Only load leaves IDLE.
- Load, any state:
  - data < MOD: dout=data next edge, load_err=0.
  - data >= MOD: dout=MOD-1, load_err=1.
  - Either way, next state is COUNT, and no decrement happens in the load cycle.
  - tc=0 in the cycle following a load.
- COUNT, en=1:
  - dout>0: dout=dout-1.
  - dout=0: dout=MOD-1 and tc=1 for exactly that next cycle.
  - Stay in COUNT.
- COUNT, en=0: dout holds, next state PAUSE.
- PAUSE:
  - dout holds.
  - en=1: decrement as in COUNT (including the wrap/tc rule), state=COUNT.
  - en=0: stay.
- busy=1 in COUNT and PAUSE.
- tc latency: tc is high in the same cycle that dout first shows MOD-1 after 0. tc is never asserted two cycles in a row unless MOD=1.
- Load of 0 with en=1 held: next cycle dout=0, following cycle dout=37 with tc=1.
- load_err is cleared only by rst or a valid load.
- Arithmetic is unsigned WIDTH-bit; dout never exceeds MOD-1.

Optional Feature:
ONE_SHOT_EN
- Defined: on the COUNT/PAUSE decrement from dout=0, dout stays 0, tc=1 for one cycle, and state goes to IDLE (busy=0 next cycle). A new load is required to restart.
- Undefined: free-running wrap to MOD-1 as described in Behaviour, with busy staying high.

Test Plan:
- Reset then idle: rst=1 for one edge, en=1, no load for 5 cycles -> dout=0, busy=0, tc=0 throughout.
- Load and count: load data=5 with en=1 held -> dout sequence 5,4,3,2,1,0,37,36 across consecutive edges; tc=1 only on the 37 cycle; busy=1 from the edge after load.
- Out-of-range load: data=6'd40 with load -> dout=37, load_err=1; then a valid load data=10 -> dout=10, load_err=0.
- Pause/resume: load 8, en=1 for 2 cycles (dout=6), en=0 for 3 cycles -> dout holds 6 and state is PAUSE; en=1 -> dout=5.
- Simultaneous events:
  - load=1, data=20 in the cycle where dout=0 and en=1 -> dout=20, tc=0 (load wins).
  - rst=1 with load=1 -> dout=0, busy=0.
- ONE_SHOT_EN build: load 2, en=1 -> dout 2,1,0,0; tc=1 on the first cycle of the second 0; busy=0 from that cycle on; further en is ignored until a new load.

Source files
------------

// File: rtl/mod_38_down_counter_if.sv
// Load/count interface shared by the mod-38 counter family.
// The master drives the preset, load strobe and enable; the slave (counter)
// returns the registered count and status flags.
interface mod_38_down_counter_if #(
  parameter int WIDTH = 6
);
  logic [WIDTH-1:0] data;
  logic             load;
  logic             en;
  logic [WIDTH-1:0] dout;
  logic             tc;
  logic             busy;
  logic             load_err;

  modport master (
    output data, load, en,
    input  dout, tc, busy, load_err
  );

  modport slave (
    input  data, load, en,
    output dout, tc, busy, load_err
  );
endinterface

// File: rtl/mod_38_down_counter.sv
// Loadable modulo-MOD down counter with terminal-count pulse.
// Counts from a loaded preset toward zero; on the step below zero it wraps
// to MOD-1 and pulses tc for one cycle. Out-of-range presets load MOD-1 and
// set the sticky load_err flag.
// Build option: define ONE_SHOT_EN to stop at zero (tc pulse, return to IDLE)
// instead of wrapping; a new load is then required to restart.
module mod_38_down_counter #(
  parameter int MOD   = 38,
  parameter int WIDTH = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  mod_38_down_counter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    COUNT = 2'b01,
    PAUSE = 2'b10
  } state_t;

  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MOD - 1);
  // One extra bit so the range check still works when MOD == 2**WIDTH.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MOD);

  state_t           state_q, state_nxt;
  logic [WIDTH-1:0] dout_q, dout_nxt;
  logic             tc_q, tc_nxt;
  logic             busy_q, busy_nxt;
  logic             err_q, err_nxt;

  // Next-state and next-output logic: load beats counting; en only matters
  // once the counter has been loaded (COUNT or PAUSE).
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one
    // unassigned; otherwise synthesis infers a latch.
    state_nxt = state_q;
    dout_nxt  = dout_q;
    tc_nxt    = 1'b0;
    err_nxt   = err_q;

    if (bus.load) begin
      state_nxt = COUNT;
      if ({1'b0, bus.data} < MOD_EXT) begin
        dout_nxt = bus.data;
        err_nxt  = 1'b0;
      end else begin
        dout_nxt = MAX_CNT;
        err_nxt  = 1'b1;
      end
    end else begin
      case (state_q)
        IDLE: begin
          // Hold until a load arrives; en has no effect here.
        end
        COUNT, PAUSE: begin
          if (bus.en) begin
            state_nxt = COUNT;
            if (dout_q == '0) begin
              tc_nxt = 1'b1;
`ifdef ONE_SHOT_EN
              // Stop at zero; dout keeps its 0 and the counter goes idle.
              state_nxt = IDLE;
`else
              dout_nxt  = MAX_CNT;
`endif
            end else begin
              dout_nxt = dout_q - 1'b1;
            end
          end else begin
            state_nxt = PAUSE;
          end
        end
        default: begin
          // Unused fourth encoding: recover to IDLE with the count held.
          state_nxt = IDLE;
        end
      endcase
    end

    busy_nxt = (state_nxt == COUNT) || (state_nxt == PAUSE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q <= IDLE;
      dout_q  <= '0;
      tc_q    <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_nxt;
      dout_q  <= dout_nxt;
      tc_q    <= tc_nxt;
      busy_q  <= busy_nxt;
      err_q   <= err_nxt;
    end
  end

  assign bus.dout     = dout_q;
  assign bus.tc       = tc_q;
  assign bus.busy     = busy_q;
  assign bus.load_err = err_q;

endmodule

// File: tb/tb_mod_38_down_counter.sv
// Directed testbench for mod_38_down_counter. Expected values are
// hand-computed; the ONE_SHOT_EN build swaps in the stop-at-zero tables.
module tb_mod_38_down_counter;

  localparam int MOD   = 38;
  localparam int WIDTH = 6;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  mod_38_down_counter_if #(.WIDTH(WIDTH)) bus ();

  mod_38_down_counter #(.MOD(MOD), .WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One rising edge, then settle so outputs are sampled away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input int d, input int t,
                           input int b);
    check({tag, ".dout"}, 32'(bus.dout), d);
    check({tag, ".tc"},   32'(bus.tc),   t);
    check({tag, ".busy"}, 32'(bus.busy), b);
  endtask

  task automatic do_load(input int value);
    bus.load = 1'b1;
    bus.data = WIDTH'(value);
    step();
    bus.load = 1'b0;
  endtask

`ifdef ONE_SHOT_EN
  int seq_dout [7] = '{4, 3, 2, 1, 0, 0, 0};
  int seq_busy [7] = '{1, 1, 1, 1, 1, 0, 0};
`else
  int seq_dout [7] = '{4, 3, 2, 1, 0, 37, 36};
  int seq_busy [7] = '{1, 1, 1, 1, 1, 1, 1};
`endif
  int seq_tc   [7] = '{0, 0, 0, 0, 0, 1, 0};

  initial begin
    checks   = 0;
    errors   = 0;
    rst      = 1'b1;
    bus.load = 1'b0;
    bus.en   = 1'b1;
    bus.data = '0;

    // Reset, then idle with en high: nothing moves without a load.
    step();
    check_out("reset", 0, 0, 0);
    check("reset.load_err", 32'(bus.load_err), 0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check_out($sformatf("idle%0d", i), 0, 0, 0);
    end

    // Load 5 with en held: no decrement in the load cycle, then count down.
    do_load(5);
    check_out("load5", 5, 0, 1);
    for (int i = 0; i < 7; i++) begin
      step();
      check_out($sformatf("cnt%0d", i), seq_dout[i], seq_tc[i], seq_busy[i]);
    end

    // Out-of-range preset clamps to MOD-1 and flags; a valid load clears it.
    do_load(40);
    check_out("load40", 37, 0, 1);
    check("load40.load_err", 32'(bus.load_err), 1);
    step();
    check("err_sticky", 32'(bus.load_err), 1);
    do_load(10);
    check_out("load10", 10, 0, 1);
    check("load10.load_err", 32'(bus.load_err), 0);

    // Pause and resume.
    do_load(8);
    check_out("load8", 8, 0, 1);
    step();
    step();
    check_out("run2", 6, 0, 1);
    bus.en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_out($sformatf("pause%0d", i), 6, 0, 1);
    end
    check("pause.state", 32'(dut.state_q), 2);
    bus.en = 1'b1;
    step();
    check_out("resume", 5, 0, 1);
    check("resume.state", 32'(dut.state_q), 1);

    // Load wins over the wrap when dout is 0 and en is high.
    do_load(1);
    step();
    check_out("at_zero", 0, 0, 1);
    do_load(20);
    check_out("load_over_wrap", 20, 0, 1);

    // Load of 0 with en held: 0, then the wrap/terminal cycle.
    do_load(0);
    check_out("load0", 0, 0, 1);
    step();
`ifdef ONE_SHOT_EN
    check_out("load0.tc", 0, 1, 0);
    step();
    check_out("load0.after", 0, 0, 0);
`else
    check_out("load0.tc", 37, 1, 1);
    step();
    check_out("load0.after", 36, 0, 1);
`endif

    // Reset beats a simultaneous load and clears the sticky error.
    do_load(50);
    check("load50.load_err", 32'(bus.load_err), 1);
    rst      = 1'b1;
    bus.load = 1'b1;
    bus.data = WIDTH'(9);
    step();
    check_out("rst_load", 0, 0, 0);
    check("rst_load.load_err", 32'(bus.load_err), 0);
    rst      = 1'b0;
    bus.load = 1'b0;
    step();
    check_out("post_rst", 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
